// File: rtl/shifter_arbiter.sv
// shifter_arbiter: two-requester round-robin front end for a shared,
// purely combinational shifter. A granted requester's operands are
// registered onto the SH_* bus, held for SETTLE_CYCLES cycles, and the
// shifter result is then captured into OUT. The requester is told the
// result is ready with a one-cycle ACK pulse.
//
// Ports:
//   CLK, N_RST                  clock, asynchronous active-low reset
//   REQ0/1                      operation request per requester
//   IN0/1, SHFT0/1              operand and shift amount per requester
//   SEL0/1                      0 shl, 1 shr, 2 signext8, 3 signext16
//   ARITH0/1                    arithmetic right shift request
//   ACK0/1                      one-cycle completion pulse to the owner
//   SH_IN/SH_SHFT/SH_SEL/SH_ARITH  registered drive to shared shifter
//   SH_OUT                      combinational result from shared shifter
//   OUT                         registered result, held until next capture
//   BUSY                        high whenever not IDLE
module shifter_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1    // legal range 1..15
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [31:0] IN0,
    input  logic [31:0] IN1,
    input  logic [4:0]  SHFT0,
    input  logic [4:0]  SHFT1,
    input  logic [1:0]  SEL0,
    input  logic [1:0]  SEL1,
    input  logic        ARITH0,
    input  logic        ARITH1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [31:0] SH_IN,
    output logic [4:0]  SH_SHFT,
    output logic [1:0]  SH_SEL,
    output logic        SH_ARITH,
    input  logic [31:0] SH_OUT,
    output logic [31:0] OUT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t     state_q, state_d;
    logic       last_q;     // index of the most recently granted requester
    logic       owner_q;    // requester owning the operation in flight
    logic [3:0] cnt_q;

    logic       any_req;
    logic       gnt_idx;

    // On a tie, the requester not granted last time wins; otherwise the
    // lone requester wins (REQ1 alone selects index 1).
    always_comb begin
        any_req = REQ0 | REQ1;
        gnt_idx = (REQ0 & REQ1) ? ~last_q : REQ1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = SETTLE;
            SETTLE:  if (cnt_q == 4'd1) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            SH_IN    <= '0;
            SH_SHFT  <= '0;
            SH_SEL   <= '0;
            SH_ARITH <= 1'b0;
            OUT      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= gnt_idx;
                        last_q  <= gnt_idx;
                        cnt_q   <= 4'(SETTLE_CYCLES);
                        if (gnt_idx) begin
                            SH_IN    <= IN1;
                            SH_SHFT  <= SHFT1;
                            SH_SEL   <= SEL1;
                            SH_ARITH <= ARITH1 & (SEL1 == 2'd1);
                        end else begin
                            SH_IN    <= IN0;
                            SH_SHFT  <= SHFT0;
                            SH_SEL   <= SEL0;
                            SH_ARITH <= ARITH0 & (SEL0 == 2'd1);
                        end
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        OUT <= SH_OUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ACK0 = (state_q == RESP) & ~owner_q;
        ACK1 = (state_q == RESP) &  owner_q;
        BUSY = (state_q != IDLE);
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter: instance A (SETTLE_CYCLES=1) and
// instance B (SETTLE_CYCLES=3), each driving its own model of the shared
// shifter. Stimulus pushes {owner, result} into a per-instance queue; a
// monitor pops and compares on every ACK.
module tb_shifter_arbiter;

    logic clk = 1'b0;
    logic n_rst;

    logic        a_req0, a_req1, a_ar0, a_ar1;
    logic [31:0] a_in0, a_in1;
    logic [4:0]  a_shft0, a_shft1;
    logic [1:0]  a_sel0, a_sel1;
    logic        a_ack0, a_ack1, a_sh_arith, a_busy;
    logic [31:0] a_sh_in, a_sh_out, a_out;
    logic [4:0]  a_sh_shft;
    logic [1:0]  a_sh_sel;

    logic        b_req0, b_req1, b_ar0, b_ar1;
    logic [31:0] b_in0, b_in1;
    logic [4:0]  b_shft0, b_shft1;
    logic [1:0]  b_sel0, b_sel1;
    logic        b_ack0, b_ack1, b_sh_arith, b_busy;
    logic [31:0] b_sh_in, b_sh_out, b_out;
    logic [4:0]  b_sh_shft;
    logic [1:0]  b_sh_sel;

    logic [32:0] qa[$];
    logic [32:0] qb[$];
    int vectors = 0;
    int miscompares = 0;

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] shift_model(input logic [31:0] din, input logic [4:0] sh,
                                                input logic [1:0] sel, input logic ar);
        logic [31:0] r;
        case (sel)
            2'd0:    r = din << sh;
            2'd1:    r = ar ? 32'($signed(din) >>> sh) : din >> sh;
            2'd2:    r = {{24{din[7]}}, din[7:0]};
            default: r = {{16{din[15]}}, din[15:0]};
        endcase
        return r;
    endfunction

    assign a_sh_out = shift_model(a_sh_in, a_sh_shft, a_sh_sel, a_sh_arith);
    assign b_sh_out = shift_model(b_sh_in, b_sh_shft, b_sh_sel, b_sh_arith);

    shifter_arbiter #(.SETTLE_CYCLES(1)) dut_a (
        .CLK(clk), .N_RST(n_rst),
        .REQ0(a_req0), .REQ1(a_req1), .IN0(a_in0), .IN1(a_in1),
        .SHFT0(a_shft0), .SHFT1(a_shft1), .SEL0(a_sel0), .SEL1(a_sel1),
        .ARITH0(a_ar0), .ARITH1(a_ar1), .ACK0(a_ack0), .ACK1(a_ack1),
        .SH_IN(a_sh_in), .SH_SHFT(a_sh_shft), .SH_SEL(a_sh_sel), .SH_ARITH(a_sh_arith),
        .SH_OUT(a_sh_out), .OUT(a_out), .BUSY(a_busy)
    );

    shifter_arbiter #(.SETTLE_CYCLES(3)) dut_b (
        .CLK(clk), .N_RST(n_rst),
        .REQ0(b_req0), .REQ1(b_req1), .IN0(b_in0), .IN1(b_in1),
        .SHFT0(b_shft0), .SHFT1(b_shft1), .SEL0(b_sel0), .SEL1(b_sel1),
        .ARITH0(b_ar0), .ARITH1(b_ar1), .ACK0(b_ack0), .ACK1(b_ack1),
        .SH_IN(b_sh_in), .SH_SHFT(b_sh_shft), .SH_SEL(b_sh_sel), .SH_ARITH(b_sh_arith),
        .SH_OUT(b_sh_out), .OUT(b_out), .BUSY(b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: every ACK must match the head of the queue.
    always @(negedge clk) begin
        if (a_ack0 | a_ack1) begin
            logic [32:0] e;
            if (a_ack0 & a_ack1) check("a_ack_overlap", 32'(a_ack0 & a_ack1), 32'd0);
            if (qa.size() == 0) begin
                check("a_unexpected_ack", {30'd0, a_ack1, a_ack0}, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_ack_owner", 32'(a_ack1), 32'(e[32]));
                check("a_out", a_out, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (b_ack0 | b_ack1) begin
            logic [32:0] e;
            if (b_ack0 & b_ack1) check("b_ack_overlap", 32'(b_ack0 & b_ack1), 32'd0);
            if (qb.size() == 0) begin
                check("b_unexpected_ack", {30'd0, b_ack1, b_ack0}, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_ack_owner", 32'(b_ack1), 32'(e[32]));
                check("b_out", b_out, e[31:0]);
            end
        end
    end

    // Wait (bounded) for the ACK of requester idx on A, then drop its REQ.
    task automatic wait_ack_a(input logic idx);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if ((idx ? a_ack1 : a_ack0) === 1'b1) seen = 1'b1;
        end
        if (!seen) check("a_ack_timeout", 32'd0, 32'd1);
        if (idx) a_req1 = 1'b0; else a_req0 = 1'b0;
    endtask

    task automatic set_a(input logic idx, input logic [31:0] din, input logic [4:0] sh,
                         input logic [1:0] sel, input logic ar);
        if (idx) begin
            a_in1 = din; a_shft1 = sh; a_sel1 = sel; a_ar1 = ar; a_req1 = 1'b1;
        end else begin
            a_in0 = din; a_shft0 = sh; a_sel0 = sel; a_ar0 = ar; a_req0 = 1'b1;
        end
    endtask

    task automatic issue_a(input logic idx, input logic [31:0] din, input logic [4:0] sh,
                           input logic [1:0] sel, input logic ar, input logic [31:0] exp);
        @(negedge clk);
        set_a(idx, din, sh, sel, ar);
        qa.push_back({idx, exp});
        @(posedge clk); #1;
        check("a_sh_in", a_sh_in, din);
        check("a_sh_arith", 32'(a_sh_arith), 32'(ar && sel == 2'd1));
        wait_ack_a(idx);
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
        check({tag, "_acks"}, {30'd0, a_ack1, a_ack0}, 32'd0);
        check({tag, "_out"}, a_out, 32'd0);
        check({tag, "_sh_in"}, a_sh_in, 32'd0);
        check({tag, "_sh_ctl"}, {24'd0, a_sh_shft, a_sh_sel, a_sh_arith}, 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int ack_k;
        {a_req0, a_req1, a_ar0, a_ar1, b_req0, b_req1, b_ar0, b_ar1} = '0;
        {a_in0, a_in1, b_in0, b_in1} = '0;
        {a_shft0, a_shft1, b_shft0, b_shft1} = '0;
        {a_sel0, a_sel1, b_sel0, b_sel1} = '0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2 check_a_reset("rst_por");
        check("b_rst_busy", 32'(b_busy), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Basic left shift with latency check: SH_* at edge G, ACK after G+1.
        @(negedge clk);
        set_a(1'b0, 32'h0000_0001, 5'd4, 2'd0, 1'b0);
        qa.push_back({1'b0, 32'h0000_0010});
        @(posedge clk); #1;
        check("lat_sh_in", a_sh_in, 32'h0000_0001);
        check("lat_sh_shft", 32'(a_sh_shft), 32'd4);
        check("lat_busy", 32'(a_busy), 32'd1);
        check("lat_ack_early", 32'(a_ack0), 32'd0);
        @(posedge clk); #1;
        check("lat_ack0", 32'(a_ack0), 32'd1);
        wait_ack_a(1'b0);

        // Single-request operations, including ARITH dropped on a left shift.
        issue_a(1'b0, 32'h8000_0000, 5'd4,  2'd1, 1'b0, 32'h0800_0000);
        issue_a(1'b1, 32'h8000_0000, 5'd4,  2'd1, 1'b1, 32'hF800_0000);
        issue_a(1'b0, 32'h0000_8001, 5'd0,  2'd3, 1'b0, 32'hFFFF_8001);
        issue_a(1'b1, 32'h0000_007F, 5'd0,  2'd2, 1'b1, 32'h0000_007F);
        issue_a(1'b1, 32'h8000_0000, 5'd1,  2'd0, 1'b1, 32'h0000_0000);

        // Tie right after reset: requester 0 first, then requester 1.
        @(negedge clk); n_rst = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        set_a(1'b0, 32'h4000_0000, 5'd2,  2'd1, 1'b1);
        set_a(1'b1, 32'h8000_0000, 5'd31, 2'd1, 1'b1);
        qa.push_back({1'b0, 32'h1000_0000});
        qa.push_back({1'b1, 32'hFFFF_FFFF});
        wait_ack_a(1'b0);
        wait_ack_a(1'b1);

        // Reset during SETTLE: abandoned with no ACK, outputs cleared
        // between clock edges, then a tie goes to requester 0.
        @(negedge clk);
        set_a(1'b0, 32'h0000_0001, 5'd1, 2'd0, 1'b0);
        @(posedge clk); #2;
        check("mid_busy_pre", 32'(a_busy), 32'd1);
        n_rst = 1'b0;
        #1 check_a_reset("rst_mid");
        @(negedge clk);
        set_a(1'b0, 32'h0000_0003, 5'd1, 2'd0, 1'b0);
        set_a(1'b1, 32'h0000_FF00, 5'd0, 2'd3, 1'b0);
        qa.push_back({1'b0, 32'h0000_0006});
        qa.push_back({1'b1, 32'hFFFF_FF00});
        n_rst = 1'b1;
        wait_ack_a(1'b0);
        wait_ack_a(1'b1);

        // SETTLE_CYCLES=3: BUSY for 4 cycles, ACK after edge G+3, operand
        // change during SETTLE ignored.
        @(negedge clk);
        b_in0 = 32'h0000_0080; b_shft0 = 5'd0; b_sel0 = 2'd2; b_ar0 = 1'b0; b_req0 = 1'b1;
        qb.push_back({1'b0, 32'hFFFF_FF80});
        @(posedge clk);
        busy_cnt = 0;
        ack_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) b_in0 = 32'h0000_0001;
            if (b_busy) busy_cnt++;
            if (b_ack0 && ack_k == 0) begin
                ack_k = k;
                b_req0 = 1'b0;
            end
        end
        check("b_busy_cycles", 32'(busy_cnt), 32'd4);
        check("b_ack_cycle", 32'(ack_k), 32'd4);
        check("b_sh_in_held", b_sh_in, 32'h0000_0080);

        repeat (3) @(negedge clk);
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
